// File: rtl/wb_pkg.sv
// Shared definitions for the writeback load unit.
// Holds the access-size encodings, the FSM state type and the alignment helper
// used by the top level when deciding whether a load may wait for RAM data.
package wb_pkg;

  localparam logic [1:0] SIZE_BYTE  = 2'd0;
  localparam logic [1:0] SIZE_HALF  = 2'd1;
  localparam logic [1:0] SIZE_WORD  = 2'd2;
  localparam logic [1:0] SIZE_DWORD = 2'd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  // lane is the byte offset within the data word (zero-extended to 3 bits);
  // dword_ok is set only when the datapath is 64 bits wide.
  function automatic logic is_aligned(input logic [1:0] size,
                                      input logic [2:0] lane,
                                      input logic       dword_ok);
    logic ok;
    case (size)
      SIZE_BYTE:  ok = 1'b1;
      SIZE_HALF:  ok = (lane[0] == 1'b0);
      SIZE_WORD:  ok = (lane[1:0] == 2'b00);
      SIZE_DWORD: ok = dword_ok & (lane == 3'd0);
      default:    ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/load_extract.sv
// Combinational lane extraction for loads.
// Ports:
//   i_rdata    RAM read data word
//   i_lane     byte offset of the access within the word
//   i_size     access size (byte/half/word/dword)
//   i_sign_ext sign-extend (1) or zero-extend (0) the selected lane
//   o_data     extracted, extended value
module load_extract
  import wb_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] i_rdata,
  input  logic [2:0]            i_lane,
  input  logic [1:0]            i_size,
  input  logic                  i_sign_ext,
  output logic [DATA_WIDTH-1:0] o_data
);

  logic [DATA_WIDTH-1:0]        w_shifted;
  logic [6:0]                   w_pad;
  logic signed [DATA_WIDTH-1:0] w_up;
  logic signed [DATA_WIDTH-1:0] w_sext;

  // Move the lane to bit 0, push it to the top, then shift back down
  // arithmetically or logically to get the requested extension.
  always_comb begin
    w_shifted = i_rdata >> {i_lane, 3'b000};
    case (i_size)
      SIZE_BYTE: w_pad = 7'(DATA_WIDTH - 8);
      SIZE_HALF: w_pad = 7'(DATA_WIDTH - 16);
      SIZE_WORD: w_pad = 7'(DATA_WIDTH - 32);
      default:   w_pad = 7'd0;
    endcase
    w_up   = w_shifted << w_pad;
    w_sext = w_up >>> w_pad;
    if (i_sign_ext) begin
      o_data = w_sext;
    end else begin
      o_data = w_up >> w_pad;
    end
  end

endmodule

// File: rtl/wb_load_unit.sv
// Writeback stage with a variable-latency RAM read path.
// Accepts one retiring instruction from MEM (valid/ready), waits for RAM data
// on aligned loads, extracts and extends the loaded lane and issues a
// one-cycle regfile write together with misalignment/timeout error flags.
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   in_valid / in_ready         MEM handshake; ready only in IDLE
//   in_load/store/sign_ext/size instruction kind and load attributes
//   in_result                   ALU result / effective address
//   in_reg_write_en/_addr, in_pc destination and PC of the instruction
//   ram_rdata / ram_rvalid      one-cycle RAM read response
//   result_out, reg_write_en_out, reg_write_addr_out  regfile write port
//   out_valid                   one-cycle retire pulse
//   err_misalign, err_timeout   error flags, pulse with out_valid
//   debug_pc_addr_out           PC of the retiring instruction
module wb_load_unit
  import wb_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int TIMEOUT        = 255
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic                      in_load,
  input  logic                      in_store,
  input  logic                      in_sign_ext,
  input  logic [1:0]                in_size,
  input  logic [DATA_WIDTH-1:0]     in_result,
  input  logic                      in_reg_write_en,
  input  logic [REG_ADDR_WIDTH-1:0] in_reg_write_addr,
  input  logic [ADDR_WIDTH-1:0]     in_pc,
  input  logic [DATA_WIDTH-1:0]     ram_rdata,
  input  logic                      ram_rvalid,
  output logic [DATA_WIDTH-1:0]     result_out,
  output logic                      reg_write_en_out,
  output logic [REG_ADDR_WIDTH-1:0] reg_write_addr_out,
  output logic                      out_valid,
  output logic                      err_misalign,
  output logic                      err_timeout,
  output logic [ADDR_WIDTH-1:0]     debug_pc_addr_out
);

  localparam int          LANE_W   = $clog2(DATA_WIDTH / 8);
  localparam logic        DWORD_OK = (DATA_WIDTH == 64);
  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

  state_t                    r_state;
  logic                      r_in_ready;
  logic [15:0]               r_cnt;
  // Fields of the accepted instruction, held while a load is outstanding.
  logic [1:0]                r_size;
  logic [2:0]                r_lane;
  logic                      r_sign_ext;
  logic                      r_wen;
  logic [REG_ADDR_WIDTH-1:0] r_rd;
  logic [ADDR_WIDTH-1:0]     r_pc;
  // Registered outputs.
  logic [DATA_WIDTH-1:0]     r_result;
  logic                      r_out_wen;
  logic [REG_ADDR_WIDTH-1:0] r_out_rd;
  logic                      r_out_valid;
  logic                      r_err_misalign;
  logic                      r_err_timeout;
  logic [ADDR_WIDTH-1:0]     r_out_pc;

  logic [2:0]                w_in_lane;
  logic                      w_in_aligned;
  logic [DATA_WIDTH-1:0]     w_load_data;

  assign w_in_lane    = 3'(in_result[LANE_W-1:0]);
  assign w_in_aligned = is_aligned(in_size, w_in_lane, DWORD_OK);

  load_extract #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_extract (
    .i_rdata    (ram_rdata),
    .i_lane     (r_lane),
    .i_size     (r_size),
    .i_sign_ext (r_sign_ext),
    .o_data     (w_load_data)
  );

  // Control FSM with all outputs registered; outputs are zero outside RESP.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= IDLE;
      r_in_ready     <= 1'b1;
      r_cnt          <= 16'd0;
      r_size         <= 2'd0;
      r_lane         <= 3'd0;
      r_sign_ext     <= 1'b0;
      r_wen          <= 1'b0;
      r_rd           <= '0;
      r_pc           <= '0;
      r_result       <= '0;
      r_out_wen      <= 1'b0;
      r_out_rd       <= '0;
      r_out_valid    <= 1'b0;
      r_err_misalign <= 1'b0;
      r_err_timeout  <= 1'b0;
      r_out_pc       <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid && r_in_ready) begin
            r_in_ready <= 1'b0;
            r_cnt      <= 16'd0;
            r_size     <= in_size;
            r_lane     <= w_in_lane;
            r_sign_ext <= in_sign_ext;
            r_wen      <= in_reg_write_en;
            r_rd       <= in_reg_write_addr;
            r_pc       <= in_pc;
            if (in_load && !in_store && w_in_aligned) begin
              r_state <= WAIT;
            end else begin
              // Retire straight away: ALU op, store, or a load that cannot go to RAM.
              r_state        <= RESP;
              r_out_valid    <= 1'b1;
              r_out_rd       <= in_reg_write_addr;
              r_out_pc       <= in_pc;
              r_err_timeout  <= 1'b0;
              r_err_misalign <= in_load & ~in_store;
              r_result       <= (in_store || in_load) ? '0 : in_result;
              r_out_wen      <= in_reg_write_en & ~in_store & ~in_load;
            end
          end
        end
        WAIT: begin
          // A response arriving on the timeout cycle still counts as data.
          if (ram_rvalid) begin
            r_state       <= RESP;
            r_out_valid   <= 1'b1;
            r_out_rd      <= r_rd;
            r_out_pc      <= r_pc;
            r_result      <= w_load_data;
            r_out_wen     <= r_wen;
            r_err_timeout <= 1'b0;
          end else if (r_cnt == CNT_LAST) begin
            r_state       <= RESP;
            r_out_valid   <= 1'b1;
            r_out_rd      <= r_rd;
            r_out_pc      <= r_pc;
            r_result      <= '0;
            r_out_wen     <= 1'b0;
            r_err_timeout <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        RESP: begin
          r_state        <= IDLE;
          r_in_ready     <= 1'b1;
          r_out_valid    <= 1'b0;
          r_out_wen      <= 1'b0;
          r_result       <= '0;
          r_out_rd       <= '0;
          r_out_pc       <= '0;
          r_err_misalign <= 1'b0;
          r_err_timeout  <= 1'b0;
        end
        default: begin
          r_state    <= IDLE;
          r_in_ready <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready           = r_in_ready;
  assign result_out         = r_result;
  assign reg_write_en_out   = r_out_wen;
  assign reg_write_addr_out = r_out_rd;
  assign out_valid          = r_out_valid;
  assign err_misalign       = r_err_misalign;
  assign err_timeout        = r_err_timeout;
  assign debug_pc_addr_out  = r_out_pc;

endmodule

// File: tb/tb_wb_load_unit.sv
// Scoreboard bench: a 32-bit and a 64-bit instance receive the same stimulus;
// the expected retire of each is computed from the load rules and queued when
// the instruction is presented, and a monitor pops and compares on out_valid.
module tb_wb_load_unit;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  int          cyc = 0;

  logic        in_valid, in_load, in_store, in_sign_ext, in_wen, ram_rvalid;
  logic [1:0]  in_size;
  logic [63:0] in_result, ram_rdata;
  logic [4:0]  in_rd;
  logic [31:0] in_pc;

  logic        rdy32, wen32, ov32, em32, et32;
  logic [31:0] res32, pc32;
  logic [4:0]  rd32;
  logic        rdy64, wen64, ov64, em64, et64;
  logic [63:0] res64;
  logic [31:0] pc64;
  logic [4:0]  rd64;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  wb_load_unit #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .REG_ADDR_WIDTH(5), .TIMEOUT(TO)) dut32 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy32), .in_load(in_load),
    .in_store(in_store), .in_sign_ext(in_sign_ext), .in_size(in_size),
    .in_result(in_result[31:0]), .in_reg_write_en(in_wen), .in_reg_write_addr(in_rd),
    .in_pc(in_pc), .ram_rdata(ram_rdata[31:0]), .ram_rvalid(ram_rvalid),
    .result_out(res32), .reg_write_en_out(wen32), .reg_write_addr_out(rd32),
    .out_valid(ov32), .err_misalign(em32), .err_timeout(et32), .debug_pc_addr_out(pc32));

  wb_load_unit #(.DATA_WIDTH(64), .ADDR_WIDTH(32), .REG_ADDR_WIDTH(5), .TIMEOUT(TO)) dut64 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy64), .in_load(in_load),
    .in_store(in_store), .in_sign_ext(in_sign_ext), .in_size(in_size),
    .in_result(in_result), .in_reg_write_en(in_wen), .in_reg_write_addr(in_rd),
    .in_pc(in_pc), .ram_rdata(ram_rdata), .ram_rvalid(ram_rvalid),
    .result_out(res64), .reg_write_en_out(wen64), .reg_write_addr_out(rd64),
    .out_valid(ov64), .err_misalign(em64), .err_timeout(et64), .debug_pc_addr_out(pc64));

  typedef struct {
    logic [63:0] result;
    logic        wen;
    logic [4:0]  rd;
    logic [31:0] pc;
    logic        mis;
    logic        tmo;
    int          cyc;
  } exp_t;

  exp_t q32[$];
  exp_t q64[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input int w, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s dut%0d: got %h expected %h (cycle %0d)", name, w, got, exp, cyc);
    end
  endtask

  // Expected retire for one instruction. k is the WAIT cycle (1-based) in which
  // rvalid is driven, 0 for never; n1 is the cycle right after the accept edge.
  function automatic exp_t model(input int dw, input bit ld, input bit st, input bit sx,
                                 input int size, input logic [63:0] res, input bit wen,
                                 input logic [4:0] rd, input logic [31:0] pc,
                                 input logic [63:0] rdata, input int k, input int n1);
    exp_t e;
    int bytes, lane;
    logic [63:0] dmask, fmask, v;
    dmask = (dw == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
    e.result = 64'd0; e.wen = 1'b0; e.rd = rd; e.pc = pc;
    e.mis = 1'b0; e.tmo = 1'b0; e.cyc = n1;
    if (!st && !ld) begin
      e.result = res & dmask;
      e.wen    = wen;
    end else if (!st) begin
      bytes = 1 << size;
      lane  = int'(res[5:0]) % (dw / 8);
      if (bytes > dw / 8 || (lane % bytes) != 0) begin
        e.mis = 1'b1;
      end else if (k < 1 || k > TO) begin
        e.tmo = 1'b1;
        e.cyc = n1 + TO;
      end else begin
        e.cyc = n1 + k;
        fmask = (bytes == 8) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (8 * bytes)) - 64'd1);
        v = ((rdata & dmask) >> (8 * lane)) & fmask;
        if (sx && v[8 * bytes - 1]) v = v | ~fmask;
        e.result = v & dmask;
        e.wen    = wen;
      end
    end
    return e;
  endfunction

  task automatic check_out(input int w, input exp_t e, input logic [63:0] res, input logic wen,
                           input logic [4:0] rd, input logic [31:0] pc, input logic mis, input logic tmo);
    chk("result", w, res, e.result);
    chk("wen", w, 64'(wen), 64'(e.wen));
    chk("waddr", w, 64'(rd), 64'(e.rd));
    chk("pc", w, 64'(pc), 64'(e.pc));
    chk("err_misalign", w, 64'(mis), 64'(e.mis));
    chk("err_timeout", w, 64'(tmo), 64'(e.tmo));
    chk("retire_cycle", w, 64'(cyc), 64'(e.cyc));
  endtask

  // Monitor: compare every retire against the scoreboard; flags must be quiet otherwise.
  always @(negedge clk) begin
    if (!rst) begin
      if (ov32) begin
        if (q32.size() == 0) chk("unexpected_valid", 32, 64'd1, 64'd0);
        else check_out(32, q32.pop_front(), {32'd0, res32}, wen32, rd32, pc32, em32, et32);
      end else begin
        chk("quiet", 32, {61'd0, wen32, em32, et32}, 64'd0);
      end
      if (ov64) begin
        if (q64.size() == 0) chk("unexpected_valid", 64, 64'd1, 64'd0);
        else check_out(64, q64.pop_front(), res64, wen64, rd64, pc64, em64, et64);
      end else begin
        chk("quiet", 64, {61'd0, wen64, em64, et64}, 64'd0);
      end
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (!(rdy32 && rdy64) && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!(rdy32 && rdy64)) chk("ready_timeout", 0, {62'd0, rdy32, rdy64}, 64'd3);
  endtask

  task automatic issue(input bit ld, input bit st, input bit sx, input int size,
                       input logic [63:0] res, input bit wen, input logic [4:0] rd,
                       input logic [31:0] pc, input logic [63:0] rdata, input int k);
    wait_ready();
    in_load = ld; in_store = st; in_sign_ext = sx; in_size = 2'(size);
    in_result = res; in_wen = wen; in_rd = rd; in_pc = pc; ram_rdata = rdata;
    in_valid = 1'b1;
    q32.push_back(model(32, ld, st, sx, size, res, wen, rd, pc, rdata, k, cyc + 1));
    q64.push_back(model(64, ld, st, sx, size, res, wen, rd, pc, rdata, k, cyc + 1));
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("ready_low_after_accept", 0, {62'd0, rdy32, rdy64}, 64'd0);
    if (k > 0) begin
      repeat (k - 1) begin @(posedge clk); #1; end
      ram_rvalid = 1'b1;
      @(posedge clk); #1;
      ram_rvalid = 1'b0;
    end
    wait_ready();
  endtask

  initial begin
    in_valid = 1'b0; in_load = 1'b0; in_store = 1'b0; in_sign_ext = 1'b0; in_wen = 1'b0;
    in_size = 2'd0; in_result = 64'd0; in_rd = 5'd0; in_pc = 32'd0;
    ram_rdata = 64'd0; ram_rvalid = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    chk("reset_ready", 0, {62'd0, rdy32, rdy64}, 64'd3);
    chk("reset_outs32", 32, {27'd0, ov32, wen32, em32, et32, rd32, res32} | 64'(pc32), 64'd0);
    chk("reset_outs64", 64, res64 | 64'(pc64) | {54'd0, ov64, wen64, em64, et64, rd64}, 64'd0);

    // Directed cases.
    issue(0, 0, 0, 2, 64'h1234_5678, 1, 5'd5, 32'h100, 64'd0, 0);
    issue(1, 0, 1, 0, 64'h1001, 1, 5'd7, 32'h104, 64'h0000_8000, 3);
    issue(1, 0, 0, 0, 64'h1001, 1, 5'd7, 32'h108, 64'h0000_8000, 3);
    issue(1, 0, 1, 1, 64'h1003, 1, 5'd8, 32'h10C, 64'd0, 0);
    issue(1, 0, 0, 2, 64'h2000, 1, 5'd9, 32'h110, 64'hDEAD_BEEF, 0);
    issue(1, 0, 0, 2, 64'h2000, 1, 5'd9, 32'h114, 64'hDEAD_BEEF, TO);
    issue(1, 0, 0, 3, 64'h3000, 1, 5'd10, 32'h118, 64'h8000_0000_0000_0001, 2);
    issue(1, 0, 1, 2, 64'h3004, 1, 5'd11, 32'h11C, 64'h8000_0000_8765_4321, 1);
    issue(0, 1, 0, 2, 64'h4000, 1, 5'd12, 32'h120, 64'd0, 0);

    // Reset while both instances wait on a load; the late response must be ignored.
    wait_ready();
    in_load = 1'b1; in_store = 1'b0; in_size = 2'd2; in_result = 64'h5000;
    in_wen = 1'b1; in_rd = 5'd13; in_pc = 32'h124; in_valid = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    chk("midwait_reset_ready", 0, {62'd0, rdy32, rdy64}, 64'd3);
    ram_rvalid = 1'b1;
    @(posedge clk); #1 ram_rvalid = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    chk("midwait_reset_outs", 0, {58'd0, ov32, wen32, ov64, wen64, rdy32, rdy64}, 64'd3);

    // Randomized traffic.
    for (int i = 0; i < 150; i++) begin
      int kind;
      kind = int'($urandom_range(0, 3));
      issue(kind >= 2, kind == 1, 1'($urandom), int'($urandom_range(0, 3)),
            {$urandom, $urandom}, 1'($urandom), 5'($urandom), $urandom,
            {$urandom, $urandom}, int'($urandom_range(0, TO + 2)));
    end

    repeat (3) begin @(posedge clk); #1; end
    chk("scoreboard_drained", 0, 64'(q32.size() + q64.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
